// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RISC-V style M-extension unit.
// Multiplies with one shift-add step per cycle and divides with one
// restoring step per cycle. Signed operations run on magnitudes and the
// selected result is negated at the output. Divide-by-zero and the signed
// overflow case bypass the iteration and complete one cycle after acceptance.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic [2:0]      op_code,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out
);

  localparam int CNT_W = $clog2(XLEN);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

  // Two's complement negation of an XLEN-bit value.
  function automatic logic [XLEN-1:0] neg_x(input logic [XLEN-1:0] v);
    logic signed [XLEN-1:0] s;
    s = -$signed(v);
    return $unsigned(s);
  endfunction

  // Two's complement negation of a full-width product.
  function automatic logic [2*XLEN-1:0] neg_2x(input logic [2*XLEN-1:0] v);
    logic signed [2*XLEN-1:0] s;
    s = -$signed(v);
    return $unsigned(s);
  endfunction

  // State. hi_q/lo_q hold {product high, product low} for multiply and
  // {partial remainder, dividend-shifting-into-quotient} for divide.
  // opnd_q holds the multiplicand magnitude or the divisor magnitude.
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [XLEN-1:0]  opnd_q, opnd_d;
  logic [XLEN-1:0]  hi_q, hi_d;
  logic [XLEN-1:0]  lo_q, lo_d;
  logic             neg_q, neg_d;

  // Operand decode at the input: signedness, magnitudes, special cases.
  logic            a_sgn, b_sgn, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            is_div, div_zero, div_ovf;

  // Decode which operands are interpreted as signed for the requested op.
  always_comb begin
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    case (op_code)
      OP_MULH, OP_DIV, OP_REM: begin
        a_sgn = 1'b1;
        b_sgn = 1'b1;
      end
      OP_MULHSU: a_sgn = 1'b1;
      default: ;
    endcase
    a_neg    = a_sgn & in_a[XLEN-1];
    b_neg    = b_sgn & in_b[XLEN-1];
    a_mag    = a_neg ? neg_x(in_a) : in_a;
    b_mag    = b_neg ? neg_x(in_b) : in_b;
    is_div   = op_code[2];
    div_zero = is_div && (in_b == '0);
    div_ovf  = ((op_code == OP_DIV) || (op_code == OP_REM)) &&
               (in_a == MOST_NEG) && (in_b == ALL_ONES);
  end

  // One iteration of each algorithm, computed from the current state.
  logic [XLEN:0]   msum;
  logic [XLEN-1:0] mul_hi, mul_lo;
  logic [XLEN:0]   dshift, ddiff;
  logic [XLEN-1:0] div_hi, div_lo;

  // Shift-add multiply step and restoring divide step.
  always_comb begin
    msum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    mul_hi = msum[XLEN:1];
    mul_lo = {msum[0], lo_q[XLEN-1:1]};

    dshift = {hi_q, lo_q[XLEN-1]};
    ddiff  = dshift - {1'b0, opnd_q};
    if (!ddiff[XLEN]) begin
      div_hi = ddiff[XLEN-1:0];
      div_lo = {lo_q[XLEN-2:0], 1'b1};
    end else begin
      div_hi = dshift[XLEN-1:0];
      div_lo = {lo_q[XLEN-2:0], 1'b0};
    end
  end

  // Next-state logic: flush wins over every handshake.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    opnd_d  = opnd_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    neg_d   = neg_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            op_d  = op_code;
            cnt_d = '0;
            if (div_zero) begin
              state_d = S_DONE;
              hi_d    = in_a;
              lo_d    = ALL_ONES;
              neg_d   = 1'b0;
            end else if (div_ovf) begin
              state_d = S_DONE;
              hi_d    = '0;
              lo_d    = in_a;
              neg_d   = 1'b0;
            end else begin
              state_d = S_CALC;
              hi_d    = '0;
              // Remainder follows the dividend sign; everything else the XOR.
              neg_d   = (op_code == OP_REM) ? a_neg : (a_neg ^ b_neg);
              if (is_div) begin
                opnd_d = b_mag;
                lo_d   = a_mag;
              end else begin
                opnd_d = a_mag;
                lo_d   = b_mag;
              end
            end
          end
        end
        S_CALC: begin
          if (op_q[2]) begin
            hi_d = div_hi;
            lo_d = div_lo;
          end else begin
            hi_d = mul_hi;
            lo_d = mul_lo;
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(XLEN - 1)) begin
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State registers; reset clears everything and overrides flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      opnd_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      opnd_q  <= opnd_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      neg_q   <= neg_d;
    end
  end

  // Result selection and sign fix-up; output is zero outside DONE.
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   div_sel, div_fix;
  logic [XLEN-1:0]   result;

  // Form the visible result from the held state.
  always_comb begin
    prod     = {hi_q, lo_q};
    prod_fix = neg_q ? neg_2x(prod) : prod;
    div_sel  = op_q[1] ? hi_q : lo_q;
    div_fix  = neg_q ? neg_x(div_sel) : div_sel;
    if (state_q != S_DONE) begin
      result = '0;
    end else if (op_q[2]) begin
      result = div_fix;
    end else if (op_q == OP_MUL) begin
      result = prod_fix[XLEN-1:0];
    end else begin
      result = prod_fix[2*XLEN-1:XLEN];
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign out       = result;

endmodule
